// File: rtl/tiny_soc_pkg.sv
// Shared types and constants for tiny_soc: memory-port widths, fixed dump/stop
// addresses, the sequencer state enum and the phase terminal-count helper.
package tiny_soc_pkg;

   localparam int SRAM_ADDR_WIDTH = 21;
   localparam int SRAM_DATA_WIDTH = 128;
   localparam int XLEN            = 64;
   localparam int NUM_DUMP_REGS   = 31;
   localparam int CNT_WIDTH       = 16;

   typedef logic [SRAM_ADDR_WIDTH-1:0] addr_t;
   typedef logic [SRAM_DATA_WIDTH-1:0] data_t;
   typedef logic [SRAM_DATA_WIDTH-1:0] strb_t;
   typedef logic [XLEN-1:0]            xreg_t;
   typedef logic [CNT_WIDTH-1:0]       cnt_t;

   localparam addr_t ADDR_STOP      = addr_t'(0);
   localparam addr_t ADDR_IREG_DUMP = addr_t'(1);

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_COMPUTE,
      ST_DUMP,
      ST_STOP,
      ST_HALT
   } state_t;

   // Phase counters start at 0 and count down; a phase of len cycles ends when
   // the counter reaches -(len-1).
   function automatic cnt_t phase_tc(input int unsigned len);
      return cnt_t'(0) - cnt_t'(len - 1);
   endfunction

endpackage

// File: rtl/tiny_soc_sram.sv
// Single-port SRAM, DEPTH x 128, per-bit write strobe, registered read that
// returns the pre-write content on a write access.
module tiny_soc_sram
   import tiny_soc_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic  clk_sys,
   input  logic  rst_b,
   input  logic  req,
   input  logic  we,
   input  addr_t addr,
   input  data_t wdata,
   input  strb_t strb,
   output data_t rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   data_t            mem [0:DEPTH-1];
   logic [IDX_W-1:0] idx;

   assign idx = IDX_W'(addr % addr_t'(DEPTH));

   // Array contents intentionally survive reset.
   always_ff @(posedge clk_sys) begin
      if (req && we) begin
         mem[idx] <= (mem[idx] & ~strb) | (wdata & strb);
      end
   end

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         rdata <= '0;
      end else if (req) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/tiny_soc.sv
// tiny_soc: boot delay, Fibonacci register fill, optional register dump to
// memory (macro TINY_SOC_DUMP_EN), stop write, then halt until reset.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_BOOT    | idle for BOOT_CYCLES edges after reset release
// ST_COMPUTE | 31 cycles filling x1..x31 with the Fibonacci sequence
// ST_DUMP    | 31 writes of x1..x31 to address 1 (TINY_SOC_DUMP_EN only)
// ST_STOP    | single write of 0 to address 0
// ST_HALT    | no traffic; terminal until reset
module tiny_soc
   import tiny_soc_pkg::*;
#(
   parameter int BOOT_CYCLES = 16,
   parameter int SRAM_DEPTH  = 256
) (
   input  logic       i_pad_clk,
   input  logic       i_pad_rst_b,
   input  logic       i_pad_jtg_tclk,
   input  logic       i_pad_jtg_tdi,
   input  logic       i_pad_jtg_tms,
   input  logic       i_pad_jtg_trst_b,
   input  logic       i_pad_uart0_sin,
   output logic       o_pad_jtg_tdo,
   output logic       o_pad_uart0_sout,
   inout  wire  [7:0] b_pad_gpio_porta,
   output logic       mem_req_o,
   output addr_t      mem_addr_o,
   output data_t      mem_wdata_o,
   output strb_t      mem_strb_o,
   output logic       mem_we_o,
   output data_t      mem_rdata_o
);

   state_t     state;
   state_t     state_next;
   cnt_t       cnt;
   logic       cnt_tc;
   logic [4:0] idx;
   xreg_t      xreg [0:NUM_DUMP_REGS];

   logic  req_d;
   logic  we_d;
   addr_t addr_d;
   data_t wdata_d;
   strb_t strb_d;
   logic  unused_pads;

   assign o_pad_jtg_tdo    = 1'b0;
   assign o_pad_uart0_sout = 1'b1;
   assign b_pad_gpio_porta = 8'bzzzz_zzzz;
   assign unused_pads      = ^{i_pad_jtg_tclk, i_pad_jtg_tdi, i_pad_jtg_tms,
                               i_pad_jtg_trst_b, i_pad_uart0_sin};

   // The down-counter doubles as the register pointer: cnt = -j selects x(j+1).
   assign idx = 5'd1 - cnt[4:0];

   always_comb begin
      cnt_tc = 1'b0;
      case (state)
         ST_BOOT:             cnt_tc = (cnt == phase_tc(BOOT_CYCLES));
         ST_COMPUTE, ST_DUMP: cnt_tc = (cnt == phase_tc(NUM_DUMP_REGS));
         default:             cnt_tc = 1'b0;
      endcase
   end

   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         state <= ST_BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT: begin
            if (cnt_tc) state_next = ST_COMPUTE;
         end
         ST_COMPUTE: begin
`ifdef TINY_SOC_DUMP_EN
            if (cnt_tc) state_next = ST_DUMP;
`else
            if (cnt_tc) state_next = ST_STOP;
`endif
         end
         ST_DUMP: begin
            if (cnt_tc) state_next = ST_STOP;
         end
         ST_STOP: state_next = ST_HALT;
         default: state_next = ST_HALT;
      endcase
   end

   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         cnt <= '0;
      end else if (state_next != state) begin
         cnt <= '0;
      end else if (state != ST_HALT) begin
         cnt <= cnt - cnt_t'(1);
      end
   end

   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         for (int i = 0; i <= NUM_DUMP_REGS; i++) begin
            xreg[i] <= '0;
         end
      end else if (state == ST_COMPUTE) begin
         xreg[idx] <= (idx == 5'd1) ? xreg_t'(1) : xreg[idx - 5'd1] + xreg[idx - 5'd2];
      end
   end

   always_comb begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      strb_d  = '0;
      case (state)
`ifdef TINY_SOC_DUMP_EN
         ST_DUMP: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = ADDR_IREG_DUMP;
            wdata_d = {{(SRAM_DATA_WIDTH-XLEN){1'b0}}, xreg[idx]};
            strb_d  = '1;
         end
`endif
         ST_STOP: begin
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = ADDR_STOP;
            wdata_d = '0;
            strb_d  = '1;
         end
         default: begin
            req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_pad_clk or negedge i_pad_rst_b) begin
      if (!i_pad_rst_b) begin
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_strb_o  <= '0;
      end else begin
         mem_req_o   <= req_d;
         mem_we_o    <= we_d;
         mem_addr_o  <= addr_d;
         mem_wdata_o <= wdata_d;
         mem_strb_o  <= strb_d;
      end
   end

   tiny_soc_sram #(
      .DEPTH(SRAM_DEPTH)
   ) u_sram (
      .clk_sys (i_pad_clk),
      .rst_b   (i_pad_rst_b),
      .req     (mem_req_o),
      .we      (mem_we_o),
      .addr    (mem_addr_o),
      .wdata   (mem_wdata_o),
      .strb    (mem_strb_o),
      .rdata   (mem_rdata_o)
   );

endmodule

// File: tb/tb_tiny_soc.sv
// Directed bench for tiny_soc: vector table over the first run, then reset
// abort and restart sequences; adapts to TINY_SOC_DUMP_EN.
module tb_tiny_soc;
   import tiny_soc_pkg::*;

`ifdef TINY_SOC_DUMP_EN
   localparam int          EXP_DUMPS  = 31;
   localparam int          ABORT_EDGE = 52;
   localparam addr_t       FIRST_ADDR = ADDR_IREG_DUMP;
   localparam logic [63:0] ABORT_WLO  = 64'd5;
   localparam logic [63:0] RERUN_RD   = 64'd3;
`else
   localparam int          EXP_DUMPS  = 0;
   localparam int          ABORT_EDGE = 48;
   localparam addr_t       FIRST_ADDR = ADDR_STOP;
   localparam logic [63:0] ABORT_WLO  = 64'd0;
   localparam logic [63:0] RERUN_RD   = 64'd0;
`endif

   logic      clk = 1'b0;
   logic      rst_b;
   logic      tclk, tdi, tms, trst_b, sin;
   wire       tdo, sout;
   wire [7:0] gpio;
   logic      req, we;
   addr_t     addr;
   data_t     wdata, rdata;
   strb_t     strb;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          edge_n;
      logic        req;
      addr_t       addr;
      logic [63:0] wlo;
      logic        chk_rd;
      logic [63:0] rd_lo;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   tiny_soc #(
      .BOOT_CYCLES(16),
      .SRAM_DEPTH (256)
   ) dut (
      .i_pad_clk        (clk),
      .i_pad_rst_b      (rst_b),
      .i_pad_jtg_tclk   (tclk),
      .i_pad_jtg_tdi    (tdi),
      .i_pad_jtg_tms    (tms),
      .i_pad_jtg_trst_b (trst_b),
      .i_pad_uart0_sin  (sin),
      .o_pad_jtg_tdo    (tdo),
      .o_pad_uart0_sout (sout),
      .b_pad_gpio_porta (gpio),
      .mem_req_o        (req),
      .mem_addr_o       (addr),
      .mem_wdata_o      (wdata),
      .mem_strb_o       (strb),
      .mem_we_o         (we),
      .mem_rdata_o      (rdata)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".req"},   128'(req),   128'(0));
      check({tag, ".we"},    128'(we),    128'(0));
      check({tag, ".addr"},  128'(addr),  128'(0));
      check({tag, ".wdata"}, wdata,       128'(0));
      check({tag, ".strb"},  strb,        128'(0));
      check({tag, ".rdata"}, rdata,       128'(0));
      check({tag, ".sout"},  128'(sout),  128'(1));
      check({tag, ".tdo"},   128'(tdo),   128'(0));
   endtask

   task automatic check_vec(input vec_t v);
      string tag;
      tag = $sformatf("e%0d", v.edge_n);
      check({tag, ".req"},   128'(req),  128'(v.req));
      check({tag, ".we"},    128'(we),   128'(v.req));
      check({tag, ".addr"},  128'(addr), 128'(v.addr));
      check({tag, ".wdata"}, wdata,      {64'h0, v.wlo});
      check({tag, ".strb"},  strb,       v.req ? {128{1'b1}} : 128'(0));
      if (v.chk_rd) check({tag, ".rdata"}, rdata, {64'h0, v.rd_lo});
   endtask

   initial begin
      int vi;
      int n_dump;
      int n_stop;
      int n_other;
      int first_req;
      int n_early;

      vecs.push_back(vec_t'{1,  1'b0, ADDR_STOP, 64'h0, 1'b1, 64'h0});
      vecs.push_back(vec_t'{16, 1'b0, ADDR_STOP, 64'h0, 1'b1, 64'h0});
      vecs.push_back(vec_t'{47, 1'b0, ADDR_STOP, 64'h0, 1'b1, 64'h0});
`ifdef TINY_SOC_DUMP_EN
      vecs.push_back(vec_t'{48, 1'b1, ADDR_IREG_DUMP, 64'h1,      1'b1, 64'h0});
      vecs.push_back(vec_t'{49, 1'b1, ADDR_IREG_DUMP, 64'h1,      1'b0, 64'h0});
      vecs.push_back(vec_t'{50, 1'b1, ADDR_IREG_DUMP, 64'h2,      1'b1, 64'h1});
      vecs.push_back(vec_t'{57, 1'b1, ADDR_IREG_DUMP, 64'h37,     1'b1, 64'h15});
      vecs.push_back(vec_t'{78, 1'b1, ADDR_IREG_DUMP, 64'h148ADD, 1'b1, 64'h7D8B5});
      vecs.push_back(vec_t'{79, 1'b1, ADDR_STOP,      64'h0,      1'b1, 64'hCB228});
      vecs.push_back(vec_t'{80, 1'b0, ADDR_STOP,      64'h0,      1'b0, 64'h0});
`else
      vecs.push_back(vec_t'{48, 1'b1, ADDR_STOP, 64'h0, 1'b1, 64'h0});
      vecs.push_back(vec_t'{49, 1'b0, ADDR_STOP, 64'h0, 1'b0, 64'h0});
`endif
      vecs.push_back(vec_t'{100, 1'b0, ADDR_STOP, 64'h0, 1'b0, 64'h0});

      rst_b  = 1'b0;
      tclk   = 1'b0;
      tdi    = 1'b1;
      tms    = 1'b1;
      trst_b = 1'b0;
      sin    = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");

      // Run 1: full sequence against the vector table plus a write monitor.
      rst_b     = 1'b1;
      vi        = 0;
      n_dump    = 0;
      n_stop    = 0;
      n_other   = 0;
      first_req = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         @(negedge clk);
         tclk = ~tclk;
         sin  = ~sin;
         if (req) begin
            if (first_req == 0) first_req = k;
            if (we && addr == ADDR_IREG_DUMP && n_stop == 0) n_dump++;
            else if (we && addr == ADDR_STOP) n_stop++;
            else n_other++;
         end
         if (vi < vecs.size() && vecs[vi].edge_n == k) begin
            check_vec(vecs[vi]);
            vi++;
         end
      end
      check("first_req_edge", 128'(first_req), 128'(48));
      check("dump_writes",    128'(n_dump),    128'(EXP_DUMPS));
      check("stop_writes",    128'(n_stop),    128'(1));
      check("stray_writes",   128'(n_other),   128'(0));

      // Run 2: abort mid-sequence with an asynchronous reset.
      rst_b = 1'b0;
      @(negedge clk);
      check_idle("rerun_reset");
      rst_b   = 1'b1;
      n_early = 0;
      for (int k = 1; k <= ABORT_EDGE; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < 48 && req) n_early++;
         if (k == 48) check("abort_run.first_wdata", wdata, 128'(1 & (FIRST_ADDR == ADDR_IREG_DUMP)));
`ifdef TINY_SOC_DUMP_EN
         if (k == 49) check("abort_run.rdata_x31", rdata, {64'h0, 64'h148ADD});
`endif
      end
      check("abort_run.early_req", 128'(n_early), 128'(0));
      check("abort_run.addr",      128'(addr),    128'(FIRST_ADDR));
      check("abort_run.wdata",     wdata,         {64'h0, ABORT_WLO});
      check("abort_run.req",       128'(req),     128'(1));
      #1 rst_b = 1'b0;
      #1 check_idle("async_reset");
      @(negedge clk);
      @(negedge clk);
      check_idle("async_reset_hold");

      // Run 3: sequence restarts from BOOT.
      rst_b   = 1'b1;
      n_early = 0;
      for (int k = 1; k <= 50; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < 48 && req) n_early++;
         if (k == 48) begin
            check("restart.req",   128'(req),  128'(1));
            check("restart.addr",  128'(addr), 128'(FIRST_ADDR));
            check("restart.wdata", wdata,      128'(1 & (FIRST_ADDR == ADDR_IREG_DUMP)));
         end
         if (k == 49) check("restart.rdata", rdata, {64'h0, RERUN_RD});
      end
      check("restart.early_req", 128'(n_early), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
